// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-count receive path: width-generic Gray/binary
// conversion, the multi-bit-change test and the snapshot-slot action encoding.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 16;
  // Helpers work on a wide word; callers zero-extend, so WIDTH must not exceed this.
  localparam int MAX_WIDTH     = 64;

  typedef logic [MAX_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    SNAP_IDLE,
    SNAP_LOAD,
    SNAP_DROP,
    SNAP_DRAIN
  } snap_op_e;

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input word_t x);
    return (x & (x - word_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_count_reader_sync.sv
// WIDTH-wide, STAGES-deep synchroniser with enable; also exposes the value
// about to enter the final stage so the step checker can compare old vs new.
module gray_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_next
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else if (enable) begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

  generate
    if (STAGES == 1) begin : g_single
      assign o_q_next = i_d;
    end else begin : g_multi
      assign o_q_next = r_chain[STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/gray_count_reader.sv
// Receive end of a Gray-coded counter bus: synchronise, decode to binary,
// flag illegal multi-bit steps and hand out count/delta snapshots via valid/ready.
module gray_count_reader
  import gray_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_count,
  output logic [WIDTH-1:0] snap_delta,
  output logic [WIDTH-1:0] bin_count,
  output logic             step_err,
  output logic             snap_overrun,
  input  logic             err_clr
);

  logic [WIDTH-1:0] w_g_s;
  logic [WIDTH-1:0] w_g_next;
  logic             w_step_bad;
  snap_op_e         w_snap_op;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_last_snap;
  logic [WIDTH-1:0] r_snap_count;
  logic [WIDTH-1:0] r_snap_delta;
  logic             r_snap_valid;
  logic             r_step_err;
  logic             r_snap_overrun;

  gray_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .i_d      (gray_in),
    .o_q      (w_g_s),
    .o_q_next (w_g_next)
  );

  // Judge the step on the same edge that loads the new synchronised sample.
  assign w_step_bad = enable && popcount_gt1(word_t'(w_g_next ^ w_g_s));

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_snap_op = SNAP_IDLE;
    if (snap_req) begin
      w_snap_op = (!r_snap_valid || snap_ready) ? SNAP_LOAD : SNAP_DROP;
    end else if (r_snap_valid && snap_ready) begin
      w_snap_op = SNAP_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin          <= '0;
      r_step_err     <= 1'b0;
      r_snap_overrun <= 1'b0;
    end else begin
      if (enable) begin
        r_bin <= WIDTH'(gray2bin(word_t'(w_g_s)));
      end
      // A fresh error outranks a simultaneous clear.
      if (w_step_bad) begin
        r_step_err <= 1'b1;
      end else if (err_clr) begin
        r_step_err <= 1'b0;
      end
      if (w_snap_op == SNAP_DROP) begin
        r_snap_overrun <= 1'b1;
      end else if (err_clr) begin
        r_snap_overrun <= 1'b0;
      end
    end
  end

  // Reset flushes the slot outright; the consumer sees no handshake for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_snap  <= '0;
      r_snap_count <= '0;
      r_snap_delta <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      case (w_snap_op)
        SNAP_LOAD: begin
          r_snap_count <= r_bin;
          r_snap_delta <= r_bin - r_last_snap;
          r_last_snap  <= r_bin;
          r_snap_valid <= 1'b1;
        end
        SNAP_DRAIN: r_snap_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bin_count    = r_bin;
  assign snap_count   = r_snap_count;
  assign snap_delta   = r_snap_delta;
  assign snap_valid   = r_snap_valid;
  assign step_err     = r_step_err;
  assign snap_overrun = r_snap_overrun;

endmodule

// File: tb/tb_gray_count_reader.sv
// Directed bench for gray_count_reader: a vector table for counting/wrap
// snapshots plus hand-written sequences for latency, errors and overrun.
module tb_gray_count_reader;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] gray_in;
  logic         snap_req;
  logic         snap_valid;
  logic         snap_ready;
  logic [W-1:0] snap_count;
  logic [W-1:0] snap_delta;
  logic [W-1:0] bin_count;
  logic         step_err;
  logic         snap_overrun;
  logic         err_clr;

  int checks = 0;
  int errors = 0;

  gray_count_reader #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .gray_in      (gray_in),
    .snap_req     (snap_req),
    .snap_valid   (snap_valid),
    .snap_ready   (snap_ready),
    .snap_count   (snap_count),
    .snap_delta   (snap_delta),
    .bin_count    (bin_count),
    .step_err     (step_err),
    .snap_overrun (snap_overrun),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] gray;
    logic         snap;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_count;
    logic [W-1:0] exp_delta;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [W-1:0] gray, input logic snap,
                              input logic [W-1:0] exp_bin, input logic [W-1:0] exp_count,
                              input logic [W-1:0] exp_delta);
    vec_t v;
    v.rst = rst; v.gray = gray; v.snap = snap;
    v.exp_bin = exp_bin; v.exp_count = exp_count; v.exp_delta = exp_delta;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    gray_in = '0;
    tick();
    reset   = 1'b0;
  endtask

  // Drive a Gray word and let it reach bin_count (SYNC_STAGES+1 edges).
  task automatic set_gray(input logic [W-1:0] g);
    gray_in = g;
    repeat (3) tick();
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; gray_in = '0;
    snap_req = 1'b0; snap_ready = 1'b0; err_clr = 1'b0;
    repeat (2) tick();
    check("rst_bin", 32'(bin_count), 32'h0);
    check("rst_valid", 32'(snap_valid), 32'h0);
    check("rst_count", 32'(snap_count), 32'h0);
    check("rst_delta", 32'(snap_delta), 32'h0);
    check("rst_step_err", 32'(step_err), 32'h0);
    check("rst_overrun", 32'(snap_overrun), 32'h0);
    reset = 1'b0;

    // Latency: change lands exactly SYNC_STAGES+1 edges later.
    gray_in = 16'h0003;
    repeat (2) tick();
    check("lat1_early", 32'(bin_count), 32'h0000);
    tick();
    check("lat1_bin", 32'(bin_count), 32'h0002);
    gray_in = 16'h000C;
    repeat (2) tick();
    check("lat2_early", 32'(bin_count), 32'h0002);
    tick();
    check("lat2_bin", 32'(bin_count), 32'h0008);

    // Counting 0..20 with snapshots at 5 and 12, then the FFFF->0 wrap.
    vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0001, 0, 16'h0001, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0003, 0, 16'h0002, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0002, 0, 16'h0003, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0006, 0, 16'h0004, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0007, 1, 16'h0005, 16'h0005, 16'h0005));
    vecs.push_back(mk(0, 16'h0005, 0, 16'h0006, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0004, 0, 16'h0007, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h000C, 0, 16'h0008, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h000D, 0, 16'h0009, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h000F, 0, 16'h000A, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h000E, 0, 16'h000B, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h000A, 1, 16'h000C, 16'h000C, 16'h0007));
    vecs.push_back(mk(0, 16'h000B, 0, 16'h000D, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0009, 0, 16'h000E, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0008, 0, 16'h000F, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0018, 0, 16'h0010, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0019, 0, 16'h0011, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h001B, 0, 16'h0012, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h001A, 0, 16'h0013, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h001E, 0, 16'h0014, 16'h0, 16'h0));
    vecs.push_back(mk(1, 16'h8000, 0, 16'hFFFF, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h8001, 1, 16'hFFFE, 16'hFFFE, 16'hFFFE));
    vecs.push_back(mk(0, 16'h8000, 0, 16'hFFFF, 16'h0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0002));

    snap_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      set_gray(vecs[i].gray);
      check($sformatf("vec%0d_bin", i), 32'(bin_count), 32'(vecs[i].exp_bin));
      check($sformatf("vec%0d_step_err", i), 32'(step_err), 32'h0);
      if (vecs[i].snap) begin
        pulse_snap();
        check($sformatf("vec%0d_valid", i), 32'(snap_valid), 32'h1);
        check($sformatf("vec%0d_count", i), 32'(snap_count), 32'(vecs[i].exp_count));
        check($sformatf("vec%0d_delta", i), 32'(snap_delta), 32'(vecs[i].exp_delta));
        tick();
        check($sformatf("vec%0d_drain", i), 32'(snap_valid), 32'h0);
        check($sformatf("vec%0d_hold", i), 32'(snap_count), 32'(vecs[i].exp_count));
      end
    end

    // Step error timing, clear, and error-beats-clear.
    do_reset();
    snap_ready = 1'b0;
    gray_in = 16'h0003;
    tick();
    check("err_not_yet", 32'(step_err), 32'h0);
    tick();
    check("err_set", 32'(step_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 32'(step_err), 32'h0);
    gray_in = 16'h0000;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_wins_clr", 32'(step_err), 32'h1);

    // Overrun with slot full, then consume-and-refill.
    do_reset();
    snap_ready = 1'b0;
    set_gray(16'h0001); set_gray(16'h0003); set_gray(16'h0002); set_gray(16'h0006);
    pulse_snap();
    check("ovr_valid", 32'(snap_valid), 32'h1);
    check("ovr_count4", 32'(snap_count), 32'h0004);
    set_gray(16'h0007); set_gray(16'h0005); set_gray(16'h0004);
    set_gray(16'h000C); set_gray(16'h000D);
    check("ovr_bin9", 32'(bin_count), 32'h0009);
    check("ovr_stable", 32'(snap_count), 32'h0004);
    pulse_snap();
    check("ovr_flag", 32'(snap_overrun), 32'h1);
    check("ovr_count_kept", 32'(snap_count), 32'h0004);
    check("ovr_delta_kept", 32'(snap_delta), 32'h0004);
    snap_ready = 1'b1;
    pulse_snap();
    snap_ready = 1'b0;
    check("refill_valid", 32'(snap_valid), 32'h1);
    check("refill_count", 32'(snap_count), 32'h0009);
    check("refill_delta", 32'(snap_delta), 32'h0005);

    // Reset flushes a pending snapshot and all flags.
    reset   = 1'b1;
    gray_in = 16'h0000;
    tick();
    reset = 1'b0;
    check("flush_valid", 32'(snap_valid), 32'h0);
    check("flush_bin", 32'(bin_count), 32'h0000);
    check("flush_step_err", 32'(step_err), 32'h0);
    check("flush_overrun", 32'(snap_overrun), 32'h0);
    set_gray(16'h0001); set_gray(16'h0003); set_gray(16'h0002);
    pulse_snap();
    check("post_rst_count", 32'(snap_count), 32'h0003);
    check("post_rst_delta", 32'(snap_delta), 32'h0003);
    check("post_rst_step_err", 32'(step_err), 32'h0);

    // Overrun cleared by err_clr.
    pulse_snap();
    check("ovr2_flag", 32'(snap_overrun), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr2_cleared", 32'(snap_overrun), 32'h0);

    // enable=0 freezes the pipeline; snapshots still work on the frozen count.
    enable  = 1'b0;
    gray_in = 16'h0006;
    repeat (4) tick();
    check("frozen_bin", 32'(bin_count), 32'h0003);
    snap_ready = 1'b1;
    pulse_snap();
    check("frozen_snap_count", 32'(snap_count), 32'h0003);
    check("frozen_snap_delta", 32'(snap_delta), 32'h0000);
    enable = 1'b1;
    repeat (3) tick();
    check("resume_bin", 32'(bin_count), 32'h0004);
    check("resume_step_err", 32'(step_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
